// File: rtl/div_ctrl_10bit.sv
// Control FSM for a 10-bit restoring shift-and-subtract divider.
// Sequences load, shift, restore and quotient-bit strobes with a start/done handshake.
module div_ctrl_10bit #(
    parameter int N  = 10,
    parameter int CW = 4
) (
    input  logic          clk,
    input  logic          clr,
    input  logic          start,
    input  logic          ge,
    input  logic          dvz,
    output logic          ready,
    output logic          busy,
    output logic          sclr_r,
    output logic          load_dd,
    output logic          load_dv,
    output logic          shift_en,
    output logic          load_r,
    output logic          q_set,
    output logic          done,
    output logic          err,
    output logic [CW-1:0] cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_CHECK = 3'd2;
    localparam logic [2:0] S_SHIFT = 3'd3;
    localparam logic [2:0] S_TEST  = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    localparam logic [CW-1:0] LAST = CW'(N - 1);

    logic [2:0] state;
    logic [2:0] state_nxt;

    always_comb begin
        state_nxt = state;
        unique case (state)
            S_IDLE:  if (start) state_nxt = S_LOAD;
            S_LOAD:  state_nxt = S_CHECK;
            S_CHECK: state_nxt = dvz ? S_DONE : S_SHIFT;
            S_SHIFT: state_nxt = S_TEST;
            S_TEST:  state_nxt = (cnt == LAST) ? S_DONE : S_SHIFT;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= S_IDLE;
            cnt   <= '0;
            err   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == S_LOAD) begin
                cnt <= '0;
                err <= 1'b0;
            end
            if (state == S_TEST)
                cnt <= cnt + 1'b1;
            if (state == S_CHECK && dvz)
                err <= 1'b1;
        end
    end

    // ge only gates the restore strobes, and only while in TEST
    assign ready    = (state == S_IDLE);
    assign busy     = (state == S_LOAD) || (state == S_CHECK) ||
                      (state == S_SHIFT) || (state == S_TEST);
    assign sclr_r   = (state == S_LOAD);
    assign load_dd  = (state == S_LOAD);
    assign load_dv  = (state == S_LOAD);
    assign shift_en = (state == S_SHIFT);
    assign load_r   = (state == S_TEST) && ge;
    assign q_set    = (state == S_TEST) && ge;
    assign done     = (state == S_DONE);

endmodule

// File: tb/tb_div_ctrl_10bit.sv
// Randomized scoreboard bench for div_ctrl_10bit.
// Quotient bits come from integer division; the monitor rebuilds the quotient from strobes.
module tb_div_ctrl_10bit;

    localparam int N  = 10;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          clr;
    logic          start;
    logic          ge;
    logic          dvz;
    logic          ready;
    logic          busy;
    logic          sclr_r;
    logic          load_dd;
    logic          load_dv;
    logic          shift_en;
    logic          load_r;
    logic          q_set;
    logic          done;
    logic          err;
    logic [CW-1:0] cnt;

    div_ctrl_10bit #(.N(N), .CW(CW)) dut (
        .clk      (clk),
        .clr      (clr),
        .start    (start),
        .ge       (ge),
        .dvz      (dvz),
        .ready    (ready),
        .busy     (busy),
        .sclr_r   (sclr_r),
        .load_dd  (load_dd),
        .load_dv  (load_dv),
        .shift_en (shift_en),
        .load_r   (load_r),
        .q_set    (q_set),
        .done     (done),
        .err      (err),
        .cnt      (cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         done_cyc;
        logic       err;
        logic [9:0] q;
        int         nshift;
    } exp_t;

    exp_t sbq[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    logic prev_err = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Monitor: rebuild quotient and pulse counts, compare on done
    logic [9:0] acc_q = '0;
    int         acc_ns = 0;
    int         acc_nl = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!clr) begin
            if (load_dd) begin
                acc_q  = '0;
                acc_ns = 0;
                acc_nl = 0;
            end
            if (shift_en) begin
                check("cnt_in_shift", 32'(cnt), 32'(acc_ns));
                acc_q  = acc_q << 1;
                acc_ns++;
            end
            if (load_r || q_set) begin
                check("load_r_eq_q_set", 32'(load_r), 32'(q_set));
                if (q_set) acc_q[0] = 1'b1;
                acc_nl++;
            end
            if (done) begin
                if (sbq.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = sbq.pop_front();
                    check("done_cycle", 32'(cyc), 32'(e.done_cyc));
                    check("done_err", 32'(err), 32'(e.err));
                    check("quotient", 32'(acc_q), 32'(e.q));
                    check("shift_pulses", 32'(acc_ns), 32'(e.nshift));
                    check("load_r_pulses", 32'(acc_nl),
                          32'($countones(e.q)));
                end
            end
        end
    end

    task automatic run(input logic [9:0] a, input logic [9:0] b,
                       input int mode);
        exp_t       e;
        logic [9:0] qv;
        int         len;
        int         c0;
        qv  = (b == 0) ? 10'd0 : a / b;
        len = (b == 0) ? 3 : 2 * N + 3;
        @(posedge clk); #1;
        start = 1'b1;
        ge    = 1'($urandom_range(0, 1));
        dvz   = 1'($urandom_range(0, 1));
        c0    = cyc;
        e.done_cyc = c0 + len;
        e.err      = (b == 0);
        e.q        = qv;
        e.nshift   = (b == 0) ? 0 : N;
        sbq.push_back(e);
        #3;
        check("idle_ready", 32'(ready), 32'd1);
        check("err_hold", 32'(err), 32'(prev_err));
        for (int k = 1; k <= len; k++) begin
            @(posedge clk); #1;
            if (mode == 1)
                start = (k == 5) || (k == 23);
            else if (mode == 2)
                start = 1'($urandom_range(0, 1));
            else
                start = 1'b0;
            ge  = 1'($urandom_range(0, 1));
            dvz = 1'($urandom_range(0, 1));
            if (k == 2)
                dvz = (b == 0);
            if (k >= 4 && k <= 2 * N + 2 && (k % 2) == 0)
                ge = qv[9 - (k - 4) / 2];
            #3;
            if (k == 1)
                check("load_strobes",
                      32'({sclr_r, load_dd, load_dv, busy, ready}),
                      32'b11110);
            if (k == 2)
                check("err_cleared_by_load", 32'(err), 32'd0);
            if (k == 3 && b == 0)
                check("dvz_err", 32'({err, shift_en}), 32'b10);
            if (k == 3 && b != 0)
                check("first_shift", 32'({shift_en, busy}), 32'b11);
        end
        start    = 1'b0;
        prev_err = (b == 0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #4;
            check("idle_state",
                  32'({ready, busy, done, err}),
                  32'({1'b1, 1'b0, 1'b0, prev_err}));
        end
    endtask

    task automatic abort_run();
        @(posedge clk); #1;
        start = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            @(posedge clk); #1;
            start = 1'b0;
            ge    = 1'($urandom_range(0, 1));
            dvz   = (k == 2) ? 1'b0 : 1'($urandom_range(0, 1));
        end
        @(posedge clk); #2;
        clr = 1'b1;
        #1;
        check("async_clr_outputs",
              32'({ready, busy, sclr_r, load_dd, load_dv, shift_en,
                   load_r, q_set, done, err}),
              32'b1000000000);
        check("async_clr_cnt", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        clr      = 1'b0;
        prev_err = 1'b0;
    endtask

    initial begin
        logic [9:0] ra;
        logic [9:0] rb;
        clr   = 1'b1;
        start = 1'b0;
        ge    = 1'b0;
        dvz   = 1'b0;
        repeat (3) @(posedge clk);
        #4;
        check("reset_outputs",
              32'({ready, busy, sclr_r, load_dd, load_dv, shift_en,
                   load_r, q_set, done, err}),
              32'b1000000000);
        check("reset_cnt", 32'(cnt), 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;
        idle(2);

        run(10'd1023, 10'd1, 0);
        run(10'd665, 10'd1, 0);
        run(10'd500, 10'd0, 0);
        idle(4);
        run(10'd300, 10'd7, 0);
        run(10'd1000, 10'd3, 1);
        run(10'd77, 10'd5, 0);
        abort_run();
        idle(3);
        run(10'd123, 10'd4, 0);

        for (int i = 0; i < 25; i++) begin
            ra = 10'($urandom);
            rb = ($urandom_range(0, 5) == 0) ? 10'd0 : 10'($urandom);
            run(ra, rb, (i % 3 == 0) ? 0 : 2);
        end
        idle(4);
        check("scoreboard_empty", 32'(sbq.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
